// File: rtl/aes_arb_pkg.sv
// rtl/aes_arb_pkg.sv - shared types and constants for the AES request arbiter
package aes_arb_pkg;

  localparam int AES_BLK_W          = 128;
  localparam int TIMEOUT_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/aes_rr_pick.sv
// rtl/aes_rr_pick.sv - combinational round-robin winner search starting after last_grant
module aes_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic found;

  // Walk offsets 1..NREQ from last_grant; the first valid requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i == ((int'(last_grant) + off) % NREQ))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grant_id = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - shares one AES engine among NREQ requesters; AES_ARB_TIMEOUT_EN enables the WAIT watchdog
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*AES_BLK_W-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      core_start,
  output logic [AES_BLK_W-1:0]      core_din,
  input  logic                      core_done,
  input  logic [AES_BLK_W-1:0]      core_dout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [AES_BLK_W-1:0]      rsp_data,
  output logic [IDW-1:0]            rsp_id,
  output logic                      rsp_err
);

  arb_state_t           state_q, state_d;
  logic [IDW-1:0]       last_grant_q, last_grant_d;
  logic [AES_BLK_W-1:0] core_din_q, core_din_d;
  logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_id;
  logic [AES_BLK_W-1:0] sel_data;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic              rsp_err_q, rsp_err_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  aes_rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req_valid (req_valid),
    .last_grant(last_grant_q),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // One-hot mux of the winning requester's plaintext lane.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_data = sel_data | req_data[i*AES_BLK_W +: AES_BLK_W];
    end
  end

  // Next-state and data-register update for the IDLE/LAUNCH/WAIT/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    core_din_d   = core_din_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
`ifdef AES_ARB_TIMEOUT_EN
    wdog_d       = wdog_q;
    wdog_inc     = wdog_q + 1'b1;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          core_din_d   = sel_data;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
`ifdef AES_ARB_TIMEOUT_EN
        wdog_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the expiry cycle still produces a normal response.
        if (core_done) begin
          rsp_data_d = core_dout;
`ifdef AES_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = ST_RESP;
        end
`ifdef AES_ARB_TIMEOUT_EN
        else if (wdog_inc == WDOG_W'(TIMEOUT_CYCLES)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          wdog_d = wdog_inc;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; reset drops any in-flight block.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      core_din_q   <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      wdog_q       <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      core_din_q   <= core_din_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
`ifdef AES_ARB_TIMEOUT_EN
      wdog_q       <= wdog_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE) ? grant : '0;
  assign core_start = (state_q == ST_LAUNCH);
  assign core_din   = core_din_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - directed bench for aes_req_arbiter with an engine model
module tb_aes_req_arbiter;
  import aes_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 2;
`ifdef AES_ARB_TIMEOUT_EN
  localparam int TO      = 8;
  localparam int ENG_LAT = 5;
`else
  localparam int TO      = 32;
  localparam int ENG_LAT = 12;
`endif
  localparam logic [127:0] KAT_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KAT_CT = 128'h3925841d02dc09fbdc118597196a0b32;

  logic                   sys_clk;
  logic                   sys_rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*128-1:0]    req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   core_start;
  logic [127:0]           core_din;
  logic                   core_done;
  logic [127:0]           core_dout;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [127:0]           rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_err;

  logic [127:0] pt [NREQ];
  logic         eng_en;
  logic         eng_done;
  logic         stray_done;
  logic [127:0] eng_dout;
  logic         eng_busy;
  int           eng_cnt;
  int           n_checks;
  int           n_errors;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  assign req_data  = {pt[1], pt[0]};
  assign core_done = eng_done | stray_done;
  assign core_dout = eng_dout;

  aes_req_arbiter #(
    .NREQ          (NREQ),
    .IDW           (IDW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .core_start(core_start),
    .core_din  (core_din),
    .core_done (core_done),
    .core_dout (core_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  function automatic logic [127:0] model_ct(input logic [127:0] p);
    if (p == KAT_PT) return KAT_CT;
    return {p[63:0], p[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
  endfunction

  always @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      eng_busy = 1'b0;
      eng_done = 1'b0;
      eng_cnt  = 0;
      eng_dout = '0;
    end else begin
      eng_done = 1'b0;
      if (eng_busy) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) begin
          eng_busy = 1'b0;
          eng_done = eng_en;
        end
      end
      if (core_start) begin
        eng_busy = 1'b1;
        eng_cnt  = ENG_LAT;
        eng_dout = model_ct(core_din);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic run_txn(input logic [NREQ-1:0] vmask, input int exp_g, input int bp, input logic exp_err);
    logic [127:0] exp_ct;
    int k;
    int starts;
    int busy_ready;
    int bad;
    req_valid = vmask;
    #1;
    chk("req_ready_grant", req_ready, 128'd1 << exp_g);
    tick();
    chk("core_start_launch", core_start, 1);
    chk("core_din", core_din, pt[exp_g]);
    chk("req_ready_launch", req_ready, 0);
    k = 0;
    starts = 0;
    busy_ready = 0;
    while (!rsp_valid && k < 100) begin
      tick();
      k++;
      if (core_start) starts++;
      if (req_ready != 0) busy_ready++;
    end
    chk("rsp_latency", k, (eng_en ? ENG_LAT : TO) + 1);
    chk("core_start_once", starts, 0);
    chk("req_ready_wait", busy_ready, 0);
    exp_ct = exp_err ? 128'd0 : model_ct(pt[exp_g]);
    chk("rsp_data", rsp_data, exp_ct);
    chk("rsp_id", rsp_id, exp_g);
    chk("rsp_err", rsp_err, exp_err);
    bad = 0;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (!rsp_valid || rsp_data !== exp_ct || rsp_id !== IDW'(exp_g) ||
          rsp_err !== exp_err || req_ready != 0) bad++;
    end
    if (bp > 0) chk("bp_stable", bad, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout_global obs=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    eng_en     = 1'b1;
    stray_done = 1'b0;
    rsp_ready  = 1'b0;
    req_valid  = '0;
    pt[0]      = KAT_PT;
    pt[1]      = 128'h00112233445566778899aabbccddeeff;
    sys_rst_n  = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();

    // known-answer block from requester 0
    run_txn(2'b01, 0, 0, 1'b0);
    req_valid = '0;

    // fairness with both requesters held valid
    do_reset();
    run_txn(2'b11, 0, 0, 1'b0);
    run_txn(2'b11, 1, 0, 1'b0);
    run_txn(2'b11, 0, 0, 1'b0);
    run_txn(2'b11, 1, 0, 1'b0);

    // backpressure, then back-to-back grant
    run_txn(2'b11, 0, 20, 1'b0);
    run_txn(2'b11, 1, 0, 1'b0);
    req_valid = '0;

    // stray done in IDLE
    tick();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    chk("stray_rsp_valid", rsp_valid, 0);
    chk("stray_core_start", core_start, 0);
    tick();
    chk("stray_rsp_valid2", rsp_valid, 0);
    run_txn(2'b11, 0, 0, 1'b0);
    req_valid = '0;

    // reset in WAIT
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("pre_rst_core_din", core_din, pt[1]);
    chk("pre_rst_rsp_id", rsp_id, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_core_din", core_din, 0);
    chk("mid_rst_rsp_id", rsp_id, 0);
    chk("mid_rst_core_start", core_start, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    run_txn(2'b11, 0, 0, 1'b0);
    req_valid = '0;

`ifdef AES_ARB_TIMEOUT_EN
    // engine never answers: watchdog response
    eng_en = 1'b0;
    run_txn(2'b01, 0, 0, 1'b1);
    req_valid = '0;
    eng_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin request arbiter and sequencer that shares one iterative AES-128 encryption engine (fixed on-chip key) between `NREQ` requesters. It accepts one 128-bit plaintext block at a time over a valid/ready handshake and pulses the engine's start input. It captures the ciphertext when the engine signals done, then returns the result with the requester's ID over a valid/ready response channel. It sits between the system's producers and the single AES engine instance, so at most one block is in flight.

## Interface
- `NREQ`, 2: number of requesters. Legal range 2–4.
- `IDW`, 2: ID width. Must satisfy 2^IDW ≥ NREQ.
- `TIMEOUT_CYCLES`, 32: watchdog limit in WAIT. Used only when `AES_ARB_TIMEOUT_EN` is defined.
- `sys_clk`  in  1  the block's only clock. All logic is rising-edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_data`  in  NREQ*128  plaintext. Requester i occupies bits [i*128+127 : i*128].
- `req_ready`  out  NREQ  one-hot accept strobe. A transfer for requester i occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `core_start`  out  1  one-cycle start pulse to the engine.
- `core_din`  out  128  plaintext to the engine. Held stable from the start pulse until done.
- `core_done`  in  1  engine done pulse, one cycle long.
- `core_dout`  in  128  engine ciphertext. Valid in the cycle `core_done` is high.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_data`  out  128  ciphertext.
- `rsp_id`  out  IDW  index of the requester that issued the block.
- `rsp_err`  out  1  timeout indication.

## Operation
The state machine has four states: IDLE, LAUNCH, WAIT, RESP.

**IDLE**
- If any `req_valid` bit is high, pick the winner g by round robin. The search starts at `last_grant+1` and wraps modulo NREQ.
- Assert `req_ready[g]` combinationally in the same cycle.
- On that edge, latch `req_data[g]` into `core_din`, latch g into `rsp_id`, set `last_grant` to g, and go to LAUNCH.
- `req_ready` is 0 in every other state.

**LAUNCH**
- Drive `core_start`=1 for exactly this one cycle.
- Clear the watchdog counter and go to WAIT.

**WAIT**
- On `core_done`=1, latch `core_dout` into `rsp_data`, set `rsp_err`=0, and go to RESP.

**RESP**
- Hold `rsp_valid`=1 with `rsp_data`, `rsp_id` and `rsp_err` stable until `rsp_ready`=1.
- On that edge, return to IDLE.

**Boundary rules**
- A `core_done` seen outside WAIT is ignored.
- New requests are not sampled until the FSM is back in IDLE. A requester whose `req_valid` drops before it is granted loses nothing.
- If all requesters are valid at the same time, they are served in the order g = last+1, last+2, … across successive transactions.
- An invalid or unused state recovers to IDLE.

**Reset**
- Outputs reset to: `req_ready`=0, `core_start`=0, `core_din`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0.
- `last_grant` resets to NREQ-1, so requester 0 wins first after reset.
- Reset mid-transaction drops the block. The engine shares `sys_rst_n` and aborts with it.

## Timing
- Accept edge (cycle A): `core_start` is high in cycle A+1.
- `core_done` arrives at cycle A+1+L, where L is the engine latency (about 12 cycles).
- `rsp_valid` rises in the cycle after `core_done`.
- If `rsp_ready` is held high, the next accept can happen 2 cycles after the `rsp_valid` rise: one cycle in RESP, one cycle in IDLE.
- `core_start` is never high in two consecutive cycles, and is low for at least L+2 cycles between pulses. This meets the engine's rising-edge start detection.
- Combinational paths: `req_valid` → `req_ready` is combinational. No other input reaches an output combinationally.

## Configuration
- `AES_ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT.
  - If it reaches TIMEOUT_CYCLES with no `core_done`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - A `core_done` in the same cycle as the expiry wins: normal response with `rsp_err`=0.
- `AES_ARB_TIMEOUT_EN` undefined:
  - There is no counter; WAIT waits indefinitely.
  - `rsp_err` is tied to constant 0. The port stays present.

## Structure
- Shared package `aes_arb_pkg` holds:
  - state enum `arb_state_t` (IDLE, LAUNCH, WAIT, RESP);
  - `AES_BLK_W` = 128;
  - the default `TIMEOUT_CYCLES` constant.
- One sub-module, `aes_rr_pick`: purely combinational. Inputs are `req_valid` and `last_grant`; outputs are a one-hot grant and a `grant_id`.
- The FSM, the data registers and the watchdog live in `aes_req_arbiter`.

## Test plan
1. **Single known-answer block.** After reset, send `req_valid`=01 with plaintext 3243f6a8885a308d313198a2e0370734 (real engine, key 2b7e151628aed2a6abf7158809cf4f3c).
   - Expect `rsp_data`=3925841d02dc09fbdc118597196a0b32, `rsp_id`=0, `rsp_err`=0.
   - Expect `core_start` high exactly 1 cycle, in the cycle after the accept.
2. **Fairness.** Hold `req_valid`=11 for 4 transactions.
   - Expect grants in order 0,1,0,1 and `rsp_id` sequence 0,1,0,1.
   - No requester may be granted twice in a row.
3. **Response backpressure.** Hold `rsp_ready`=0 for 20 cycles after `rsp_valid` rises.
   - `rsp_*` stays stable and `req_ready` stays 0 throughout.
   - The next grant occurs 2 cycles after `rsp_ready`=1 is applied.
4. **Stray done.** Pulse `core_done` while in IDLE.
   - No `rsp_valid`, no state change.
5. **Mid-transaction reset.** Assert `sys_rst_n`=0 in WAIT.
   - All outputs go to their reset values asynchronously.
   - After release, requester 0 wins first.
6. **Timeout (`AES_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=8, engine stub never asserts done).**
   - Expect `rsp_valid` with `rsp_err`=1 and `rsp_data`=0, 9 cycles after `core_start`.
